// File: rtl/layer_scroller.sv
// Per-layer vertical scroll controller: owns the layer block map/type registers and scroll offset.
// Optional build macro SCROLL_PAUSE_EN adds an i_pause input that freezes an in-progress scroll.
module layer_scroller #(
  parameter int BLOCKS      = 7,
  parameter int LAYER_ID    = 0,
  parameter int Y_BASE      = 25,
  parameter int LAYER_PITCH = 150,
  parameter int SHIFT_DIST  = 150,
  parameter int STEP        = 1,
  parameter int TICK_DIV    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_module_en,
  input  logic              i_one_ms_tick,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_load,
`ifdef SCROLL_PAUSE_EN
  input  logic              i_pause,
`endif
  input  logic [BLOCKS-1:0] i_layer_map_in,
  input  logic [BLOCKS-1:0] i_block_type_in,
  output logic [BLOCKS-1:0] o_layer_map_out,
  output logic [BLOCKS-1:0] o_block_type_out,
  output logic [11:0]       o_ypos,
  output logic              o_busy,
  output logic              o_done
);

  localparam int SW = $clog2(SHIFT_DIST + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int YO = (Y_BASE + LAYER_ID * LAYER_PITCH) % 4096;
  localparam logic [11:0]   Y_ORIGIN = 12'(YO);
  localparam logic [SW:0]   STEP_V   = (SW + 1)'(STEP);
  localparam logic [SW:0]   DIST_W   = (SW + 1)'(SHIFT_DIST);
  localparam logic [SW-1:0] DIST_V   = SW'(SHIFT_DIST);
  localparam logic [PW-1:0] TDM1     = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    ENDS   = 2'd2
  } state_t;

  state_t              r_state, w_state_n;
  logic [SW-1:0]       r_shift, w_shift_n;
  logic [PW-1:0]       r_presc, w_presc_n;
  logic [BLOCKS-1:0]   r_map, w_map_n;
  logic [BLOCKS-1:0]   r_type, w_type_n;
  logic [SW:0]         w_sum;
  logic                w_tick;

`ifdef SCROLL_PAUSE_EN
  assign w_tick = i_one_ms_tick & ~i_pause;
`else
  assign w_tick = i_one_ms_tick;
`endif

  assign w_sum = {1'b0, r_shift} + STEP_V;

  // Next-state and datapath update; module_en low holds every register.
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_presc_n = r_presc;
    w_map_n   = r_map;
    w_type_n  = r_type;
    if (i_module_en) begin
      case (r_state)
        IDLE: begin
          if (i_load) begin
            w_map_n  = i_layer_map_in;
            w_type_n = i_block_type_in;
          end else if (i_start) begin
            w_state_n = SCROLL;
            w_shift_n = '0;
            w_presc_n = '0;
          end else begin
            w_state_n = IDLE;
          end
        end
        SCROLL: begin
          if (i_abort) begin
            w_state_n = IDLE;
            w_shift_n = '0;
            w_presc_n = '0;
          end else if (w_tick) begin
            if (r_presc == TDM1) begin
              w_presc_n = '0;
              // Last step clamps so shift never overshoots the scroll distance.
              if (w_sum >= DIST_W) begin
                w_shift_n = DIST_V;
                w_state_n = ENDS;
              end else begin
                w_shift_n = w_sum[SW-1:0];
              end
            end else begin
              w_presc_n = r_presc + PW'(1);
            end
          end else begin
            w_state_n = SCROLL;
          end
        end
        ENDS: begin
          w_state_n = IDLE;
          w_shift_n = '0;
          w_presc_n = '0;
          w_map_n   = i_layer_map_in;
          w_type_n  = i_block_type_in;
        end
        default: begin
          w_state_n = IDLE;
          w_shift_n = '0;
          w_presc_n = '0;
        end
      endcase
    end else begin
      w_state_n = r_state;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_presc <= '0;
      r_map   <= '0;
      r_type  <= '0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_presc <= w_presc_n;
      r_map   <= w_map_n;
      r_type  <= w_type_n;
    end
  end

  assign o_layer_map_out  = r_map;
  assign o_block_type_out = r_type;
  assign o_ypos           = Y_ORIGIN + 12'(r_shift);
  assign o_busy           = (r_state == SCROLL) || (r_state == ENDS);
  // done is suppressed while the block is frozen.
  assign o_done           = (r_state == ENDS) && i_module_en;

endmodule

// File: doc/layer_scroller.md
Name: layer_scroller

Overview:
- Parametrised successor of the per-layer vertical scroll controller.
- Owns one board layer's block map and block-type registers, plus its scroll offset.
- Produces the layer's screen Y position for the downstream layer renderer.
- Generalised over block count, layer index, scroll distance, step size and tick prescaling; adds abort, a done pulse and a busy flag.

Parameters:
- BLOCKS, 7, blocks per layer (width of map/type buses)
- LAYER_ID, 0, layer index; sets static Y origin
- Y_BASE, 25, Y of layer 0 in pixels
- LAYER_PITCH, 150, vertical pixel pitch between layers
- SHIFT_DIST, 150, total pixels scrolled per scroll operation (>=1)
- STEP, 1, pixels added per scroll step (1..SHIFT_DIST)
- TICK_DIV, 1, one_ms_tick pulses per scroll step (>=1)

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous active-high reset
- module_en  in  1  1 = FSM runs; 0 = all registers hold, inputs ignored
- one_ms_tick  in  1  single-cycle time base pulse
- start  in  1  begin scroll (IDLE only)
- abort  in  1  cancel scroll, no map update
- load  in  1  copy layer_map_in/block_type_in to outputs (IDLE only)
- layer_map_in  in  BLOCKS  next layer occupancy
- block_type_in  in  BLOCKS  next layer block types
- layer_map_out  out  BLOCKS  registered current occupancy
- block_type_out  out  BLOCKS  registered current types
- ypos  out  12  Y_BASE + LAYER_ID*LAYER_PITCH + shift, mod 4096; combinational from registered shift
- busy  out  1  1 in SCROLL or END
- done  out  1  one-cycle pulse on the END cycle

Behaviour:
- Single clock domain, clk. rst is synchronous and active-high and overrides everything, including a mid-scroll state.
- Reset values: state=IDLE; shift=0; prescaler=0; layer_map_out=0; block_type_out=0; done=0. Hence busy=0 and ypos equals the static origin.
- shift width is clog2(SHIFT_DIST+1). The prescaler counts 0..TICK_DIV-1.
- IDLE:
  - load=1: outputs take layer_map_in/block_type_in on the next edge.
  - start=1 with load=0: go to SCROLL; shift=0; prescaler=0.
  - load and start together: load wins; start is dropped.
  - abort is ignored.
- SCROLL:
  - On each tick, the prescaler increments. When it reaches TICK_DIV-1 it clears and a step occurs.
  - Step: shift = min(shift+STEP, SHIFT_DIST).
  - If a step lands shift on SHIFT_DIST, go to END on the same edge.
  - start and load are ignored.
  - abort=1 overrides ticks: go to IDLE, shift=0, prescaler=0, maps unchanged, no done pulse.
- END (exactly one cycle):
  - done=1.
  - On exit: shift=0; layer_map_out/block_type_out take the _in buses; return to IDLE.
  - abort is ignored in END.
- Step count per scroll = ceil(SHIFT_DIST/STEP). The last step clamps when STEP does not divide SHIFT_DIST.
- Latency from start to done = (steps*TICK_DIV ticks) + 1 cycle.
- module_en=0 freezes state, shift, prescaler and maps. Ticks arriving while frozen are lost, not queued. done is forced to 0 while frozen.
- Undefined state encodings recover to IDLE.

Optional Feature:
- Macro: SCROLL_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - In SCROLL, pause=1 discards ticks: shift and prescaler hold.
  - abort still acts while paused.
  - pause has no effect in IDLE or END.
- Undefined:
  - Port is absent.
  - Scroll always advances on qualifying ticks.

Test Plan:
- Defaults: rst 1 cycle, then load with map 7'b1010011, type 7'b0000001 → outputs equal those values next cycle; ypos=25 (LAYER_ID=0).
- Default params, start, 150 ticks spaced 10 cycles apart → ypos 25→175 by 1 per tick; done pulses once, 1 cycle after the 150th tick; shift=0 and maps reloaded from _in on the following cycle.
- SHIFT_DIST=10, STEP=4, TICK_DIV=3, LAYER_ID=2 → shift sequence 0,4,8,10 (steps every 3rd tick); done after tick 9; ypos base=325.
- Abort after 40 ticks → next cycle IDLE, ypos=25, maps unchanged, done never asserts; a subsequent start scrolls from 0.
- load+start asserted together in IDLE → maps load, state stays IDLE, busy=0. rst mid-scroll at shift=77 → all outputs at reset values next cycle.
- SCROLL_PAUSE_EN defined: pause for 20 ticks mid-scroll → shift constant during the pause, total scroll still 150 steps. module_en=0 for 5 ticks → same hold, ticks lost.
